// File: rtl/sm_cpu_arbiter.sv
// sm_cpu_arbiter: round-robin front end that time-shares one start/done
// compute unit between NUM_REQ requesters. Each granted job gets one start
// pulse, a bounded wait for done, and a one-cycle ack with the result.
//
// state  | meaning
// IDLE   | no job; scanning req from the round-robin pointer
// ISSUE  | operand latched, cu_start high for this one cycle
// WAIT   | counting cycles until done (first cycle masked) or timeout
// RESP   | ack[id] high, result/error presented, pointer advanced
module sm_cpu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_x,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           rsp_y,
  output logic                  rsp_err,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic                  cu_start,
  output logic [15:0]           cu_x,
  input  logic [31:0]           cu_y,
  input  logic                  cu_done
);

  // Wide enough to hold TIMEOUT itself so the increment never wraps.
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  wait_cnt;

  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   scan;
  logic [15:0]    grant_x;

  logic           load_grant;
  logic           take_done;
  logic           take_timeout;

  // Round-robin pick: scan from the highest offset down so the requester
  // closest to the pointer (offset 0 first) is the last, winning assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = {1'b0, ptr} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NUM_REQ)) begin
        scan = scan - (IDW+1)'(NUM_REQ);
      end
      if (req[scan[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = scan[IDW-1:0];
      end
    end
  end

  // Operand of the winning requester, only used at the grant cycle.
  always_comb begin
    grant_x = req_x[{grant_id, 4'b0000} +: 16];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    state_n      = state;
    load_grant   = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          load_grant = 1'b1;
          state_n    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // A done level left over from the previous job is ignored on the
        // first WAIT cycle; done beats timeout when both land together.
        if ((wait_cnt != '0) && cu_done) begin
          take_done = 1'b1;
          state_n   = S_RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          take_timeout = 1'b1;
          state_n      = S_RESP;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Registered outputs and job bookkeeping; every output follows state_n
  // so it lines up with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      rsp_y    <= '0;
      rsp_err  <= 1'b0;
      rsp_id   <= '0;
      busy     <= 1'b0;
      cu_start <= 1'b0;
      cu_x     <= '0;
      ptr      <= '0;
      id       <= '0;
      wait_cnt <= '0;
    end else begin
      busy     <= (state_n != S_IDLE);
      cu_start <= (state_n == S_ISSUE);
      ack      <= '0;

      if (load_grant) begin
        cu_x <= grant_x;
        id   <= grant_id;
      end

      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end

      if (take_done) begin
        rsp_y   <= cu_y;
        rsp_err <= 1'b0;
      end else if (take_timeout) begin
        rsp_y   <= '0;
        rsp_err <= 1'b1;
      end

      if (state_n == S_RESP) begin
        ack    <= NUM_REQ'(1) << id;
        rsp_id <= id;
      end

      if (state == S_RESP) begin
        ptr <= (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sm_cpu_arbiter.sv
// Directed bench for sm_cpu_arbiter with a behavioural compute unit
// (y = 3*x + 8, done pulse after 3 cycles, or done stuck low/high).
module tb_sm_cpu_arbiter;

  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] req_x = '0;
  logic [N-1:0]    ack;
  logic [31:0]     rsp_y;
  logic            rsp_err;
  logic [IDW-1:0]  rsp_id;
  logic            busy;
  logic            cu_start;
  logic [15:0]     cu_x;
  logic [31:0]     cu_y;
  logic            cu_done;

  sm_cpu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x),
    .ack(ack), .rsp_y(rsp_y), .rsp_err(rsp_err), .rsp_id(rsp_id),
    .busy(busy), .cu_start(cu_start), .cu_x(cu_x),
    .cu_y(cu_y), .cu_done(cu_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          y;
    bit          err;
    logic [15:0] x;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  int   n_ack    = 0;

  // compute unit model: 0 = normal, 1 = done stuck low, 2 = done stuck high
  int          umode = 0;
  logic [15:0] ux    = '0;
  int          ucnt  = 0;
  logic        udone = 1'b0;

  always @(posedge clk) begin
    if (cu_start) begin
      ux    <= cu_x;
      ucnt  <= 3;
      udone <= 1'b0;
    end else if (ucnt != 0) begin
      ucnt  <= ucnt - 1;
      udone <= (ucnt == 1);
    end else begin
      udone <= 1'b0;
    end
  end

  assign cu_y    = (32'($signed(ux)) * 32'sd3) + 32'sd8;
  assign cu_done = (umode == 1) ? 1'b0 : (umode == 2) ? 1'b1 : udone;

  function automatic int model(input int x);
    return 3 * x + 8;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: compare cu_x on each start and the response on each ack.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (cu_start) begin
      n_start++;
      check("start_pulse_width", 32'(prev_start), 32'd0);
      if (exp_q.size() != 0) check("cu_x", 32'(cu_x), 32'(exp_q[0].x));
    end
    prev_start = cu_start;
    if (|ack) begin
      n_ack++;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_ack: observed ack=%b expected none", ack);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("ack_vec", 32'(ack), 32'(1) << e.id);
        check("rsp_y", rsp_y, 32'(e.y));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic issue(input int id, input int x, input bit err);
    exp_t e;
    e.id  = id;
    e.y   = err ? 0 : model(x);
    e.err = err;
    e.x   = 16'(x);
    exp_q.push_back(e);
    req_x[16*id +: 16] = 16'(x);
    req[id] = 1'b1;
  endtask

  task automatic wait_ack(input bit drop, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (|ack) begin
        seen = 1'b1;
        if (drop) req = req & ~ack;
      end
    end
    n_assert++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL ack_wait: observed no ack expected ack within 40 cycles");
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (cu_start) seen = 1'b1;
    end
    n_assert++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL start_wait: observed no cu_start expected one within 20 cycles");
    end
  endtask

  initial begin
    int cyc;
    int s0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cu_start", 32'(cu_start), 32'd0);
    check("rst_cu_x", 32'(cu_x), 32'd0);
    check("rst_rsp_y", rsp_y, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // requester 0, x=10: start one cycle after req, ack one after done
    issue(0, 10, 1'b0);
    @(negedge clk);
    check("start_latency", 32'(cu_start), 32'd1);
    wait_ack(1'b1, cyc);
    check("job_latency", 32'(cyc), 32'd5);
    @(negedge clk);
    check("busy_after_ack0", 32'(busy), 32'd0);

    // requester 2 alone, negative operand
    issue(2, -4, 1'b0);
    wait_ack(1'b1, cyc);
    @(negedge clk);
    check("busy_after_ack2", 32'(busy), 32'd0);

    // requester 1 moves the pointer to 2, then 0011 must wrap to 0, then 1
    issue(1, 5, 1'b0);
    wait_ack(1'b1, cyc);
    issue(0, 100, 1'b0);
    issue(1, -200, 1'b0);
    wait_ack(1'b1, cyc);
    wait_ack(1'b1, cyc);

    // requester 3 brings the pointer back to 0
    issue(3, 7, 1'b0);
    wait_ack(1'b1, cyc);

    // all four held high: two full rotations, one start per ack
    s0 = n_start;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) issue(i, i * 11 - 20, 1'b0);
    for (int j = 0; j < 8; j++) begin
      wait_ack(1'b0, cyc);
      if (j == 7) req = '0;
    end
    repeat (2) @(negedge clk);
    check("starts_per_rotation", 32'(n_start - s0), 32'd8);

    // done never arrives: ack after exactly TO wait cycles with error
    umode = 1;
    issue(0, 1234, 1'b1);
    wait_start();
    wait_ack(1'b1, cyc);
    check("timeout_latency", 32'(cyc), 32'(TO + 1));
    umode = 0;
    issue(1, 3, 1'b0);
    wait_ack(1'b1, cyc);

    // done stuck high: first wait cycle masked, accepted on the second
    umode = 2;
    issue(2, -9, 1'b0);
    wait_start();
    wait_ack(1'b1, cyc);
    check("stale_done_latency", 32'(cyc), 32'd3);
    umode = 1;

    // reset in the middle of WAIT: outputs clear at once, no ack follows
    req_x[16*2 +: 16] = 16'd77;
    req[2] = 1'b1;
    wait_start();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_y", rsp_y, 32'd0);
    check("midrst_rsp_id", 32'(rsp_id), 32'd0);
    check("midrst_cu_x", 32'(cu_x), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    req = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    umode = 0;
    @(negedge clk);

    // first job after reset from requester 1
    issue(1, 42, 1'b0);
    wait_ack(1'b1, cyc);
    repeat (3) @(negedge clk);

    check("total_acks", 32'(n_ack), 32'd18);
    check("total_starts", 32'(n_start), 32'd19);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
